issue_queue: RTL and testbench
==============================

# issue_queue

Parametrised out-of-order reservation station between the ROB dispatch stage and the execute unit. It holds up to DEPTH instructions and snoops NCDB result broadcast channels to resolve operand tags. Each cycle it issues the oldest entry whose operands are both ready, using a valid/ready handshake towards EX, and it supports a full pipeline flush.

## Interface
- DEPTH, 16: entry count (≥2).
- DATA_W, 32: operand/PC/imm width.
- TAG_W, 5: ROB tag width; tag 0 means "no dependency".
- OP_W, 6: opcode width.
- NCDB, 2: number of result broadcast channels.
- clk  in  1  clock.
- rst  in  1  reset rst, synchronous, active-high; clock clk.
- flush  in  1  discard all entries (misprediction).
- in_valid  in  1  dispatch request.
- in_ready  out  1  at least one free entry.
- in_op  in  OP_W  opcode.
- in_pc, in_imm  in  DATA_W  PC and immediate.
- in_qs1, in_qs2  in  TAG_W  source tags.
- in_vs1, in_vs2  in  DATA_W  source values (meaningful when tag is 0).
- in_qd  in  TAG_W  destination ROB tag.
- iss_valid  out  1  ready entry presented.
- iss_ready  in  1  EX accepts.
- iss_op, iss_pc, iss_imm, iss_vs1, iss_vs2, iss_qd  out  widths as inputs  selected entry fields.
- cdb_valid  in  NCDB  per-channel broadcast valid.
- cdb_tag  in  NCDB*TAG_W  packed tags, channel c at bits [c*TAG_W +: TAG_W].
- cdb_data  in  NCDB*DATA_W  packed results.
- count  out  $clog2(DEPTH+1)  occupied entries.

## Operation
- Entry fields are valid, op, pc, imm, qs1/qs2, vs1/vs2, and qd. An entry is ready when valid && qs1==0 && qs2==0.
- Dispatch: when in_valid && in_ready, the lowest-index free entry is written. A source tag that matches an active CDB channel in the same cycle is written as tag 0 with the CDB data (insert bypass).
- Wakeup: for every valid entry and each source whose tag is nonzero and matches cdb_tag[c] with cdb_valid[c], the source captures the data and its tag clears. cdb_tag 0 is ignored. If two channels carry the same tag, the lower channel index wins; that case is illegal upstream.
- Select: iss_valid = any entry ready. The iss_* outputs are the oldest ready entry, where oldest means dispatched earliest (age matrix). Outputs are combinational from registered state. When iss_valid=0 the iss_* field values are don't-care, but they must be stable and not X after reset.
- Issue: iss_valid && iss_ready frees the selected entry at the clock edge.
- Flush: all valid bits clear at the edge. Flush takes priority over dispatch, wakeup and issue in that cycle. rst has priority over flush.
- count tracks +dispatch −issue. Simultaneous dispatch and issue leaves count unchanged.
- Dispatch while full: in_ready=0, so the request is not accepted and no state changes.

## Timing
- Reset values: in_ready=1, iss_valid=0, count=0, all iss_* fields 0, all entries invalid with tags 0.
- Dispatch at edge N: the entry is visible from cycle N+1. If it is ready, it issues in cycle N+1 at the earliest.
- CDB wakeup in cycle N: the entry can become eligible in cycle N+1. There is no CDB-to-issue combinational bypass.
- A slot freed by issue at edge N is reusable from cycle N+1. in_ready is computed from registered state only and does not reflect a same-cycle issue.
- With iss_ready=0, the selection is held unless an older entry becomes ready; EX must sample only on handshake.
- Throughput: one dispatch and one issue per cycle.
- Flush and dispatch in the same cycle: the dispatch is dropped. In cycle N+1, count=0 and iss_valid=0.

## Structure
- Shared package riscv_pkg holds TAG_W, OP_W, DATA_W defaults, NO_TAG=0, and the CDB packing helpers.
- Sub-module issue_age_matrix: a DEPTH×DEPTH age bit-matrix. On alloc, the new row is set for all currently valid entries. Inputs are the ready vector and the alloc/free one-hots; output is the oldest-ready one-hot. Everything else stays in issue_queue.

## Test plan
- Reset, then dispatch op=0x13 with qs1=qs2=0 and vs1=5 → iss_valid=1 the next cycle with iss_vs1=5 and iss_qd equal to in_qd; after the handshake, count returns to 0.
- Dispatch A (qs1=3), then B (ready); drive cdb tag 3, data 0xAA → B issues first; A issues the following cycle with iss_vs1=0xAA.
- Dispatch C (qs1=7) in the same cycle cdb_valid[1]=1 with tag 7, data 0x55 → C is ready next cycle with iss_vs1=0x55.
- Fill DEPTH entries that are not ready → in_ready=0 and count=DEPTH. An extra in_valid is ignored; one wakeup plus issue raises in_ready.
- Three ready entries with iss_ready=0 for 5 cycles → iss_qd is stable at the oldest entry. Release → entries issue in dispatch order.
- Four valid entries, then flush with a simultaneous dispatch → next cycle count=0, iss_valid=0, in_ready=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core definitions: default datapath widths, the empty-tag marker
// and accessors for the packed CDB broadcast buses.
package riscv_pkg;

   localparam int DATA_W = 32;
   localparam int TAG_W  = 5;
   localparam int OP_W   = 6;
   localparam int NCDB   = 2;

   localparam logic [TAG_W-1:0] NO_TAG = '0;

   // Channel c of a packed CDB bus lives at bits [c*width +: width]
   function automatic logic [TAG_W-1:0] cdb_get_tag(input logic [NCDB*TAG_W-1:0] tags,
                                                    input int c);
      return tags[c*TAG_W +: TAG_W];
   endfunction

   function automatic logic [DATA_W-1:0] cdb_get_data(input logic [NCDB*DATA_W-1:0] data,
                                                      input int c);
      return data[c*DATA_W +: DATA_W];
   endfunction

   function automatic logic [NCDB*TAG_W-1:0] cdb_put_tag(input logic [NCDB*TAG_W-1:0] tags,
                                                         input int c,
                                                         input logic [TAG_W-1:0] tag);
      logic [NCDB*TAG_W-1:0] r;
      r = tags;
      r[c*TAG_W +: TAG_W] = tag;
      return r;
   endfunction

   function automatic logic [NCDB*DATA_W-1:0] cdb_put_data(input logic [NCDB*DATA_W-1:0] data,
                                                           input int c,
                                                           input logic [DATA_W-1:0] value);
      logic [NCDB*DATA_W-1:0] r;
      r = data;
      r[c*DATA_W +: DATA_W] = value;
      return r;
   endfunction

endpackage

// File: rtl/issue_queue_if.sv
// Dispatch, issue and CDB snoop signals of the issue queue; the slave
// modport is the queue itself, the master side is dispatch/EX/CDB.
interface issue_queue_if #(
   parameter int DATA_W = riscv_pkg::DATA_W,
   parameter int TAG_W  = riscv_pkg::TAG_W,
   parameter int OP_W   = riscv_pkg::OP_W,
   parameter int NCDB   = riscv_pkg::NCDB
);
   import riscv_pkg::*;

   logic                   in_valid;
   logic                   in_ready;
   logic [OP_W-1:0]        in_op;
   logic [DATA_W-1:0]      in_pc;
   logic [DATA_W-1:0]      in_imm;
   logic [TAG_W-1:0]       in_qs1;
   logic [TAG_W-1:0]       in_qs2;
   logic [DATA_W-1:0]      in_vs1;
   logic [DATA_W-1:0]      in_vs2;
   logic [TAG_W-1:0]       in_qd;

   logic                   iss_valid;
   logic                   iss_ready;
   logic [OP_W-1:0]        iss_op;
   logic [DATA_W-1:0]      iss_pc;
   logic [DATA_W-1:0]      iss_imm;
   logic [DATA_W-1:0]      iss_vs1;
   logic [DATA_W-1:0]      iss_vs2;
   logic [TAG_W-1:0]       iss_qd;

   logic [NCDB-1:0]        cdb_valid;
   logic [NCDB*TAG_W-1:0]  cdb_tag;
   logic [NCDB*DATA_W-1:0] cdb_data;

   modport master (
      output in_valid, in_op, in_pc, in_imm, in_qs1, in_qs2, in_vs1, in_vs2, in_qd,
      input  in_ready,
      input  iss_valid, iss_op, iss_pc, iss_imm, iss_vs1, iss_vs2, iss_qd,
      output iss_ready,
      output cdb_valid, cdb_tag, cdb_data
   );

   modport slave (
      input  in_valid, in_op, in_pc, in_imm, in_qs1, in_qs2, in_vs1, in_vs2, in_qd,
      output in_ready,
      output iss_valid, iss_op, iss_pc, iss_imm, iss_vs1, iss_vs2, iss_qd,
      input  iss_ready,
      input  cdb_valid, cdb_tag, cdb_data
   );

endinterface

// File: rtl/issue_age_matrix.sv
// Dispatch-order bookkeeping for the issue queue: picks the oldest entry
// among those flagged ready.
module issue_age_matrix #(
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DEPTH-1:0] valid,
   input  logic [DEPTH-1:0] ready,
   input  logic [DEPTH-1:0] alloc,
   input  logic [DEPTH-1:0] free,
   output logic [DEPTH-1:0] oldest
);
   import riscv_pkg::*;

   // older_q[i][j] set means entry j was dispatched before entry i
   logic [DEPTH-1:0] older_q [DEPTH];

   // A newly allocated row records every live entry as older; the slot's
   // column is cleared everywhere so stale bits from a previous occupant vanish
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            older_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (alloc[i]) begin
               older_q[i] <= valid & ~free;
            end else if (free[i]) begin
               older_q[i] <= '0;
            end else begin
               older_q[i] <= older_q[i] & ~alloc & ~free;
            end
         end
      end
   end

   always_comb begin
      oldest = '0;
      for (int i = 0; i < DEPTH; i++) begin
         oldest[i] = ready[i] && ((older_q[i] & ready) == '0);
      end
   end

endmodule

// File: rtl/issue_queue.sv
// Out-of-order reservation station: holds dispatched instructions, wakes
// their operands from the CDB and issues the oldest ready one to EX.
module issue_queue #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = riscv_pkg::DATA_W,
   parameter int TAG_W  = riscv_pkg::TAG_W,
   parameter int OP_W   = riscv_pkg::OP_W,
   parameter int NCDB   = riscv_pkg::NCDB,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   issue_queue_if.slave     bus,
   output logic [CNT_W-1:0] count
);
   import riscv_pkg::*;

   typedef struct packed {
      logic              hit;
      logic [DATA_W-1:0] data;
   } snoop_t;

   // Lowest channel wins when several carry the same tag
   function automatic snoop_t snoop(input logic [TAG_W-1:0]       tag,
                                    input logic [NCDB-1:0]        cv,
                                    input logic [NCDB*TAG_W-1:0]  ct,
                                    input logic [NCDB*DATA_W-1:0] cd);
      snoop_t s;
      s = '0;
      for (int c = NCDB - 1; c >= 0; c--) begin
         if (cv[c] && tag != TAG_W'(NO_TAG) && ct[c*TAG_W +: TAG_W] == tag) begin
            s.hit  = 1'b1;
            s.data = cd[c*DATA_W +: DATA_W];
         end
      end
      return s;
   endfunction

   logic [DEPTH-1:0]  valid_q;
   logic [OP_W-1:0]   op_q  [DEPTH];
   logic [DATA_W-1:0] pc_q  [DEPTH];
   logic [DATA_W-1:0] imm_q [DEPTH];
   logic [TAG_W-1:0]  qs1_q [DEPTH];
   logic [TAG_W-1:0]  qs2_q [DEPTH];
   logic [DATA_W-1:0] vs1_q [DEPTH];
   logic [DATA_W-1:0] vs2_q [DEPTH];
   logic [TAG_W-1:0]  qd_q  [DEPTH];
   logic [CNT_W-1:0]  count_q;

   logic [DEPTH-1:0]  ready_vec;
   logic [DEPTH-1:0]  alloc_oh;
   logic [DEPTH-1:0]  oldest_oh;
   logic [DEPTH-1:0]  issue_oh;
   logic              dispatch_fire;
   logic              issue_fire;
   snoop_t            wake1 [DEPTH];
   snoop_t            wake2 [DEPTH];
   snoop_t            byp1;
   snoop_t            byp2;

   // Lowest-index free slot, scanned downwards so the last hit is the lowest
   always_comb begin
      alloc_oh = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            alloc_oh    = '0;
            alloc_oh[i] = 1'b1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ready_vec[i] = valid_q[i] && qs1_q[i] == TAG_W'(NO_TAG) && qs2_q[i] == TAG_W'(NO_TAG);
         wake1[i]     = snoop(qs1_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
         wake2[i]     = snoop(qs2_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
      end
      byp1 = snoop(bus.in_qs1, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
      byp2 = snoop(bus.in_qs2, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
   end

   assign bus.in_ready  = ~&valid_q;
   assign bus.iss_valid = |ready_vec;
   assign dispatch_fire = bus.in_valid && bus.in_ready;
   assign issue_fire    = bus.iss_valid && bus.iss_ready;
   assign issue_oh      = oldest_oh & {DEPTH{issue_fire}};
   assign count         = count_q;

   issue_age_matrix #(
      .DEPTH (DEPTH)
   ) u_age (
      .clk    (clk),
      .rst    (rst),
      .valid  (valid_q),
      .ready  (ready_vec),
      .alloc  (alloc_oh & {DEPTH{dispatch_fire && !flush}}),
      .free   (issue_oh & {DEPTH{!flush}}),
      .oldest (oldest_oh)
   );

   // AND-OR mux keeps the issue fields at zero whenever nothing is ready
   always_comb begin
      bus.iss_op  = '0;
      bus.iss_pc  = '0;
      bus.iss_imm = '0;
      bus.iss_vs1 = '0;
      bus.iss_vs2 = '0;
      bus.iss_qd  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         bus.iss_op  = bus.iss_op  | ({OP_W{oldest_oh[i]}}   & op_q[i]);
         bus.iss_pc  = bus.iss_pc  | ({DATA_W{oldest_oh[i]}} & pc_q[i]);
         bus.iss_imm = bus.iss_imm | ({DATA_W{oldest_oh[i]}} & imm_q[i]);
         bus.iss_vs1 = bus.iss_vs1 | ({DATA_W{oldest_oh[i]}} & vs1_q[i]);
         bus.iss_vs2 = bus.iss_vs2 | ({DATA_W{oldest_oh[i]}} & vs2_q[i]);
         bus.iss_qd  = bus.iss_qd  | ({TAG_W{oldest_oh[i]}}  & qd_q[i]);
      end
   end

   // Issue, dispatch and wakeup never touch the same slot in one cycle:
   // dispatch only targets free slots and issue only valid ones
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            op_q[i]  <= '0;
            pc_q[i]  <= '0;
            imm_q[i] <= '0;
            qs1_q[i] <= '0;
            qs2_q[i] <= '0;
            vs1_q[i] <= '0;
            vs2_q[i] <= '0;
            qd_q[i]  <= '0;
         end
      end else if (flush) begin
         valid_q <= '0;
         count_q <= '0;
      end else begin
         count_q <= count_q + CNT_W'(dispatch_fire) - CNT_W'(issue_fire);
         for (int i = 0; i < DEPTH; i++) begin
            if (issue_oh[i]) begin
               valid_q[i] <= 1'b0;
            end else if (alloc_oh[i] && dispatch_fire) begin
               valid_q[i] <= 1'b1;
               op_q[i]    <= bus.in_op;
               pc_q[i]    <= bus.in_pc;
               imm_q[i]   <= bus.in_imm;
               qd_q[i]    <= bus.in_qd;
               qs1_q[i]   <= byp1.hit ? TAG_W'(NO_TAG) : bus.in_qs1;
               vs1_q[i]   <= byp1.hit ? byp1.data : bus.in_vs1;
               qs2_q[i]   <= byp2.hit ? TAG_W'(NO_TAG) : bus.in_qs2;
               vs2_q[i]   <= byp2.hit ? byp2.data : bus.in_vs2;
            end else if (valid_q[i]) begin
               if (wake1[i].hit) begin
                  qs1_q[i] <= TAG_W'(NO_TAG);
                  vs1_q[i] <= wake1[i].data;
               end
               if (wake2[i].hit) begin
                  qs2_q[i] <= TAG_W'(NO_TAG);
                  vs2_q[i] <= wake2[i].data;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed scenarios plus random
// traffic compared against an in-order list model of the station.
module tb_issue_queue;
   import riscv_pkg::*;

   localparam int DEPTH = 16;

   typedef struct {
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] imm;
      logic [TAG_W-1:0]  qs1;
      logic [TAG_W-1:0]  qs2;
      logic [DATA_W-1:0] vs1;
      logic [DATA_W-1:0] vs2;
      logic [TAG_W-1:0]  qd;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       flush = 1'b0;
   logic [4:0] count;
   int         n_checks = 0;
   int         n_fail = 0;
   ent_t       model_q[$];

   issue_queue_if bus ();

   issue_queue #(
      .DEPTH (DEPTH)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus),
      .count (count)
   );

   always #5 clk = ~clk;

   // Model: entries kept in dispatch order, the first ready one issues
   function automatic int model_oldest();
      foreach (model_q[k]) begin
         if (model_q[k].qs1 == 0 && model_q[k].qs2 == 0) return k;
      end
      return -1;
   endfunction

   function automatic void model_snoop(inout logic [TAG_W-1:0] q, inout logic [DATA_W-1:0] v);
      if (q == 0) return;
      for (int c = 0; c < NCDB; c++) begin
         if (bus.cdb_valid[c] && cdb_get_tag(bus.cdb_tag, c) == q) begin
            v = cdb_get_data(bus.cdb_data, c);
            q = 0;
            return;
         end
      end
   endfunction

   function automatic void model_step();
      int   sel;
      int   pre_size;
      ent_t e;
      if (rst || flush) begin
         model_q.delete();
         return;
      end
      pre_size = model_q.size();
      sel = model_oldest();
      if (sel >= 0 && bus.iss_ready) model_q.delete(sel);
      foreach (model_q[k]) begin
         e = model_q[k];
         model_snoop(e.qs1, e.vs1);
         model_snoop(e.qs2, e.vs2);
         model_q[k] = e;
      end
      if (bus.in_valid && pre_size < DEPTH) begin
         e.op = bus.in_op;   e.pc = bus.in_pc;   e.imm = bus.in_imm;  e.qd = bus.in_qd;
         e.qs1 = bus.in_qs1; e.vs1 = bus.in_vs1; e.qs2 = bus.in_qs2;  e.vs2 = bus.in_vs2;
         model_snoop(e.qs1, e.vs1);
         model_snoop(e.qs2, e.vs2);
         model_q.push_back(e);
      end
   endfunction

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.in_valid  = 1'b0;
      bus.in_op     = '0;  bus.in_pc  = '0;  bus.in_imm = '0;
      bus.in_qs1    = '0;  bus.in_qs2 = '0;  bus.in_vs1 = '0;  bus.in_vs2 = '0;
      bus.in_qd     = '0;
      bus.iss_ready = 1'b0;
      bus.cdb_valid = '0;
      bus.cdb_tag   = '0;
      bus.cdb_data  = '0;
      flush         = 1'b0;
   endtask

   task automatic drive_dispatch(input logic [5:0] op, input logic [4:0] qs1,
                                 input logic [31:0] vs1, input logic [4:0] qd);
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_qs1   = qs1;
      bus.in_vs1   = vs1;
      bus.in_qs2   = '0;
      bus.in_vs2   = $urandom;
      bus.in_pc    = $urandom;
      bus.in_imm   = $urandom;
      bus.in_qd    = qd;
   endtask

   task automatic set_cdb(input int ch, input logic [4:0] tag, input logic [31:0] data);
      bus.cdb_valid[ch] = 1'b1;
      bus.cdb_tag       = cdb_put_tag(bus.cdb_tag, ch, tag);
      bus.cdb_data      = cdb_put_data(bus.cdb_data, ch, data);
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %0h expected 1", bus.in_ready); end
      n_checks++; if (bus.iss_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_iss_valid: got %0h expected 0", bus.iss_valid); end
      n_checks++; if (count !== 5'd0) begin n_fail++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
      n_checks++;
      if ({bus.iss_op, bus.iss_pc, bus.iss_imm, bus.iss_vs1, bus.iss_vs2, bus.iss_qd} !== '0) begin
         n_fail++; $display("[TB] FAIL reset_iss_fields: got op=%0h qd=%0h vs1=%0h expected all 0", bus.iss_op, bus.iss_qd, bus.iss_vs1);
      end
   endtask

   task automatic test_basic_issue();
      idle();
      bus.iss_ready = 1'b1;
      drive_dispatch(6'h13, 5'd0, 32'd5, 5'd9);
      tick();
      bus.in_valid = 1'b0;
      n_checks++; if (bus.iss_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_iss_valid: got %0h expected 1", bus.iss_valid); end
      n_checks++; if (bus.iss_vs1 !== 32'd5) begin n_fail++; $display("[TB] FAIL basic_vs1: got %0h expected 5", bus.iss_vs1); end
      n_checks++; if (bus.iss_qd !== 5'd9) begin n_fail++; $display("[TB] FAIL basic_qd: got %0h expected 9", bus.iss_qd); end
      n_checks++; if (bus.iss_op !== 6'h13) begin n_fail++; $display("[TB] FAIL basic_op: got %0h expected 13", bus.iss_op); end
      n_checks++; if (count !== 5'd1) begin n_fail++; $display("[TB] FAIL basic_count_1: got %0d expected 1", count); end
      tick();
      n_checks++; if (count !== 5'd0) begin n_fail++; $display("[TB] FAIL basic_count_0: got %0d expected 0", count); end
      n_checks++; if (bus.iss_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_drained: got %0h expected 0", bus.iss_valid); end
   endtask

   task automatic test_wakeup_order();
      idle();
      drive_dispatch(6'h01, 5'd3, 32'd0, 5'd10);
      tick();
      drive_dispatch(6'h02, 5'd0, 32'h11, 5'd11);
      tick();
      bus.in_valid  = 1'b0;
      bus.iss_ready = 1'b1;
      set_cdb(0, 5'd3, 32'hAA);
      n_checks++; if (bus.iss_qd !== 5'd11) begin n_fail++; $display("[TB] FAIL wake_b_first: got qd %0d expected 11", bus.iss_qd); end
      tick();
      bus.cdb_valid = '0;
      n_checks++; if (bus.iss_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL wake_a_valid: got %0h expected 1", bus.iss_valid); end
      n_checks++; if (bus.iss_qd !== 5'd10) begin n_fail++; $display("[TB] FAIL wake_a_qd: got %0d expected 10", bus.iss_qd); end
      n_checks++; if (bus.iss_vs1 !== 32'hAA) begin n_fail++; $display("[TB] FAIL wake_a_vs1: got %0h expected aa", bus.iss_vs1); end
      tick();
      n_checks++; if (count !== 5'd0) begin n_fail++; $display("[TB] FAIL wake_count: got %0d expected 0", count); end
   endtask

   task automatic test_insert_bypass();
      idle();
      drive_dispatch(6'h05, 5'd7, 32'd0, 5'd12);
      set_cdb(1, 5'd7, 32'h55);
      tick();
      idle();
      n_checks++; if (bus.iss_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bypass_valid: got %0h expected 1", bus.iss_valid); end
      n_checks++; if (bus.iss_vs1 !== 32'h55) begin n_fail++; $display("[TB] FAIL bypass_vs1: got %0h expected 55", bus.iss_vs1); end
      n_checks++; if (bus.iss_qd !== 5'd12) begin n_fail++; $display("[TB] FAIL bypass_qd: got %0d expected 12", bus.iss_qd); end
      bus.iss_ready = 1'b1;
      tick();
      n_checks++; if (count !== 5'd0) begin n_fail++; $display("[TB] FAIL bypass_count: got %0d expected 0", count); end
   endtask

   task automatic test_full();
      idle();
      for (int i = 0; i < DEPTH; i++) begin
         drive_dispatch(6'h07, 5'(i + 1), 32'd0, 5'(i + 1));
         tick();
      end
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL full_in_ready: got %0h expected 0", bus.in_ready); end
      n_checks++; if (count !== 5'(DEPTH)) begin n_fail++; $display("[TB] FAIL full_count: got %0d expected %0d", count, DEPTH); end
      drive_dispatch(6'h08, 5'd0, 32'd1, 5'd31);
      tick();
      bus.in_valid = 1'b0;
      n_checks++; if (count !== 5'(DEPTH)) begin n_fail++; $display("[TB] FAIL full_extra_count: got %0d expected %0d", count, DEPTH); end
      n_checks++; if (bus.iss_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL full_extra_ignored: got %0h expected 0", bus.iss_valid); end
      set_cdb(0, 5'd5, 32'h77);
      bus.iss_ready = 1'b1;
      tick();
      bus.cdb_valid = '0;
      n_checks++; if (bus.iss_qd !== 5'd5 || bus.iss_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL full_woken: got valid %0h qd %0d expected 1/5", bus.iss_valid, bus.iss_qd); end
      n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL full_still_full: got %0h expected 0", bus.in_ready); end
      tick();
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL full_slot_freed: got %0h expected 1", bus.in_ready); end
      n_checks++; if (count !== 5'(DEPTH - 1)) begin n_fail++; $display("[TB] FAIL full_count_after: got %0d expected %0d", count, DEPTH - 1); end
      idle();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   task automatic test_hold();
      idle();
      for (int i = 0; i < 3; i++) begin
         drive_dispatch(6'h09, 5'd0, 32'(100 + i), 5'(20 + i));
         tick();
      end
      bus.in_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         n_checks++; if (bus.iss_qd !== 5'd20) begin n_fail++; $display("[TB] FAIL hold_stable: cycle %0d got qd %0d expected 20", k, bus.iss_qd); end
         tick();
      end
      bus.iss_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         n_checks++; if (bus.iss_qd !== 5'(20 + k)) begin n_fail++; $display("[TB] FAIL hold_order: got qd %0d expected %0d", bus.iss_qd, 20 + k); end
         tick();
      end
      n_checks++; if (bus.iss_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL hold_drained: got %0h expected 0", bus.iss_valid); end
   endtask

   task automatic test_flush();
      idle();
      for (int i = 0; i < 4; i++) begin
         drive_dispatch(6'h0A, (i % 2 == 0) ? 5'd9 : 5'd0, 32'd0, 5'(i + 1));
         tick();
      end
      n_checks++; if (count !== 5'd4) begin n_fail++; $display("[TB] FAIL flush_pre_count: got %0d expected 4", count); end
      drive_dispatch(6'h0B, 5'd0, 32'd3, 5'd30);
      flush = 1'b1;
      tick();
      idle();
      n_checks++; if (count !== 5'd0) begin n_fail++; $display("[TB] FAIL flush_count: got %0d expected 0", count); end
      n_checks++; if (bus.iss_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_iss_valid: got %0h expected 0", bus.iss_valid); end
      n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL flush_in_ready: got %0h expected 1", bus.in_ready); end
   endtask

   task automatic test_random();
      int   sel;
      ent_t e;
      idle();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         bus.in_valid  = ($urandom_range(0, 2) != 0);
         bus.in_op     = 6'($urandom);
         bus.in_pc     = $urandom;
         bus.in_imm    = $urandom;
         bus.in_vs1    = $urandom;
         bus.in_vs2    = $urandom;
         bus.in_qs1    = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
         bus.in_qs2    = ($urandom_range(0, 1) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
         bus.in_qd     = 5'($urandom_range(1, 31));
         bus.iss_ready = ($urandom_range(0, 3) != 0);
         bus.cdb_valid = 2'($urandom);
         for (int c = 0; c < NCDB; c++) begin
            bus.cdb_tag  = cdb_put_tag(bus.cdb_tag, c, 5'($urandom_range(0, 7)));
            bus.cdb_data = cdb_put_data(bus.cdb_data, c, $urandom);
         end
         flush = ($urandom_range(0, 49) == 0);
         tick();
         sel = model_oldest();
         n_checks++; if (count !== 5'(model_q.size())) begin n_fail++; $display("[TB] FAIL rand_count: cycle %0d got %0d expected %0d", cyc, count, model_q.size()); end
         n_checks++; if (bus.in_ready !== (model_q.size() < DEPTH)) begin n_fail++; $display("[TB] FAIL rand_in_ready: cycle %0d got %0h expected %0h", cyc, bus.in_ready, model_q.size() < DEPTH); end
         n_checks++; if (bus.iss_valid !== (sel >= 0)) begin n_fail++; $display("[TB] FAIL rand_iss_valid: cycle %0d got %0h expected %0h", cyc, bus.iss_valid, sel >= 0); end
         if (sel >= 0) begin
            e = model_q[sel];
            n_checks++;
            if ({bus.iss_op, bus.iss_pc, bus.iss_imm, bus.iss_vs1, bus.iss_vs2, bus.iss_qd} !==
                {e.op, e.pc, e.imm, e.vs1, e.vs2, e.qd}) begin
               n_fail++;
               $display("[TB] FAIL rand_iss_fields: cycle %0d got qd=%0h vs1=%0h vs2=%0h expected qd=%0h vs1=%0h vs2=%0h",
                        cyc, bus.iss_qd, bus.iss_vs1, bus.iss_vs2, e.qd, e.vs1, e.vs2);
            end
         end
      end
      idle();
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      idle();
      #2;
      test_reset();
      test_basic_issue();
      test_wakeup_order();
      test_insert_bypass();
      test_full();
      test_hold();
      test_flush();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
